// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, blocking icache lookup and in-order instruction queue
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        icache_req,
  output logic [31:0] icache_pc,
  input  logic        icache_req_ready,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_inst,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = DEPTH[AW:0];
  localparam logic          ST_REQ  = 1'b0;
  localparam logic          ST_WAIT = 1'b1;

  logic          state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          drop;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];

  logic accept;
  logic resp_in_wait;
  logic push;
  logic pop;

  // Request gating: blocked in reset, while waiting, when the queue is full or on redirect.
  assign icache_req   = resetn & (state == ST_REQ) & (count < FULL) & ~redirect_valid;
  assign icache_pc    = pc;
  assign accept       = icache_req & icache_req_ready;
  assign resp_in_wait = (state == ST_WAIT) & icache_resp_valid;
  assign push         = resp_in_wait & ~drop & ~redirect_valid;
  assign pop          = out_valid & out_ready & ~redirect_valid;

  assign out_valid = (count != '0);
  assign out_pc    = q_pc[head];
  assign out_inst  = q_inst[head];

  // Control state: PC, FSM, squash flag and queue pointers; redirect overrides normal flow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      state  <= ST_REQ;
      drop   <= 1'b0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc    <= {redirect_pc[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
      if (state == ST_WAIT) begin
        if (icache_resp_valid) begin
          drop  <= 1'b0;
          state <= ST_REQ;
        end else begin
          drop  <= 1'b1;
        end
      end
    end else begin
      if (accept) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
        state  <= ST_WAIT;
      end
      if (resp_in_wait) begin
        drop  <= 1'b0;
        state <= ST_REQ;
      end
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Queue payload storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      q_pc[tail]   <= req_pc;
      q_inst[tail] <= icache_resp_inst;
    end
  end

endmodule
